// File: rtl/ptmch_trg_sched_if.sv
// Host/matcher-side bundle of the trigger scheduler: event inputs, config,
// and status/trigger outputs.
interface ptmch_trg_sched_if #(
  parameter int P_NCH   = 5,
  parameter int P_DLY_W = 8,
  parameter int P_WID_W = 8,
  parameter int P_HLD_W = 16
);
  logic               ARM;
  logic [P_NCH-1:0]   TRG_IN;
  logic [P_NCH-1:0]   CH_EN;
  logic [P_DLY_W-1:0] DLY_CFG;
  logic [P_WID_W-1:0] WID_CFG;
  logic [P_HLD_W-1:0] HLD_CFG;
  logic               OVF_CLR;
  logic               TRG_OUT;
  logic [2:0]         TRG_CH;
  logic               BUSY;
  logic [P_NCH-1:0]   PEND;
  logic [P_NCH-1:0]   OVF_STKY;
  logic [15:0]        TRG_CNT;

  modport master (
    output ARM, TRG_IN, CH_EN, DLY_CFG, WID_CFG, HLD_CFG, OVF_CLR,
    input  TRG_OUT, TRG_CH, BUSY, PEND, OVF_STKY, TRG_CNT
  );

  modport slave (
    input  ARM, TRG_IN, CH_EN, DLY_CFG, WID_CFG, HLD_CFG, OVF_CLR,
    output TRG_OUT, TRG_CH, BUSY, PEND, OVF_STKY, TRG_CNT
  );
endinterface

// File: rtl/ptmch_trg_sched.sv
// Round-robin scheduler for the SPI-opcode trigger lines: one pending event
// per channel, single trigger output with programmable delay/width/holdoff.
module ptmch_trg_sched #(
  parameter int P_NCH   = 5,
  parameter int P_DLY_W = 8,
  parameter int P_WID_W = 8,
  parameter int P_HLD_W = 16
) (
  input logic                CLK160M,
  input logic                RESET,
  ptmch_trg_sched_if.slave   bus
);

  localparam int CW = (P_HLD_W > P_DLY_W) ?
                      ((P_HLD_W > P_WID_W) ? P_HLD_W : P_WID_W) :
                      ((P_DLY_W > P_WID_W) ? P_DLY_W : P_WID_W);
  localparam int unsigned NCH_U = P_NCH;

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_PULSE, S_HOLD} state_e;

  state_e             state_q, state_d;
  logic [2:0]         ptr_q, ptr_d;
  logic [2:0]         trg_ch_q, trg_ch_d;
  logic [P_NCH-1:0]   pend_q, pend_d;
  logic [P_NCH-1:0]   ovf_q, ovf_d;
  logic [P_NCH-1:0]   trg_in_q;
  logic               trg_out_q, trg_out_d;
  logic [15:0]        cnt_q, cnt_d;
  logic [CW-1:0]      tmr_q, tmr_d;
  logic [P_WID_W-1:0] wid_m1_q, wid_m1_d;
  logic [P_HLD_W-1:0] hld_q, hld_d;

  logic [P_NCH-1:0]   ev;
  logic               gnt_vld;
  logic [2:0]         gnt_idx;
  logic               grant;

  assign ev = bus.TRG_IN & ~trg_in_q & bus.CH_EN & {P_NCH{bus.ARM}};

  // First pending channel after the last grant, wrapping modulo P_NCH.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 1; k <= NCH_U; k++) begin
      idx = (32'(ptr_q) + k) % NCH_U;
      if (!gnt_vld && pend_q[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    trg_ch_d = trg_ch_q;
    cnt_d    = cnt_q;
    tmr_d    = tmr_q;
    wid_m1_d = wid_m1_q;
    hld_d    = hld_q;
    grant    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (gnt_vld) begin
          grant    = 1'b1;
          ptr_d    = gnt_idx;
          trg_ch_d = gnt_idx;
          wid_m1_d = (bus.WID_CFG == '0) ? '0 : bus.WID_CFG - P_WID_W'(1);
          hld_d    = bus.HLD_CFG;
          if (bus.DLY_CFG == '0) begin
            state_d = S_PULSE;
            tmr_d   = CW'((bus.WID_CFG == '0) ? '0 : bus.WID_CFG - P_WID_W'(1));
            cnt_d   = cnt_q + 16'd1;
          end else begin
            state_d = S_DELAY;
            tmr_d   = CW'(bus.DLY_CFG) - CW'(1);
          end
        end
      end
      S_DELAY: begin
        if (tmr_q == '0) begin
          state_d = S_PULSE;
          tmr_d   = CW'(wid_m1_q);
          cnt_d   = cnt_q + 16'd1;
        end else begin
          tmr_d = tmr_q - CW'(1);
        end
      end
      S_PULSE: begin
        if (tmr_q != '0) begin
          tmr_d = tmr_q - CW'(1);
        end else if (hld_q == '0) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HOLD;
          tmr_d   = CW'(hld_q) - CW'(1);
        end
      end
      S_HOLD: begin
        if (tmr_q == '0) state_d = S_IDLE;
        else             tmr_d   = tmr_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    trg_out_d = (state_d == S_PULSE);
  end

  // Grant clears before the new event is merged, so a same-cycle re-trigger
  // of the granted channel re-pends without counting as an overflow.
  always_comb begin
    pend_d = pend_q;
    ovf_d  = ovf_q;
    if (bus.OVF_CLR) ovf_d = '0;
    if (grant) pend_d[gnt_idx] = 1'b0;
    ovf_d  = ovf_d | (ev & pend_d);
    pend_d = pend_d | ev;
    if (!bus.ARM) pend_d = '0;
  end

  always_ff @(posedge CLK160M) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      ptr_q     <= 3'(P_NCH - 1);
      trg_ch_q  <= '0;
      pend_q    <= '0;
      ovf_q     <= '0;
      trg_in_q  <= '0;
      trg_out_q <= 1'b0;
      cnt_q     <= '0;
      tmr_q     <= '0;
      wid_m1_q  <= '0;
      hld_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      trg_ch_q  <= trg_ch_d;
      pend_q    <= pend_d;
      ovf_q     <= ovf_d;
      trg_in_q  <= bus.TRG_IN;
      trg_out_q <= trg_out_d;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      wid_m1_q  <= wid_m1_d;
      hld_q     <= hld_d;
    end
  end

  assign bus.TRG_OUT  = trg_out_q;
  assign bus.TRG_CH   = trg_ch_q;
  assign bus.BUSY     = (state_q != S_IDLE);
  assign bus.PEND     = pend_q;
  assign bus.OVF_STKY = ovf_q;
  assign bus.TRG_CNT  = cnt_q;

endmodule

// File: tb/tb_ptmch_trg_sched.sv
// Scoreboard bench for ptmch_trg_sched: expected pulses (channel, width) are
// queued at stimulus time and matched against each observed TRG_OUT pulse.
module tb_ptmch_trg_sched;

  logic CLK160M = 1'b0;
  logic RESET   = 1'b1;

  always #3 CLK160M = ~CLK160M;

  ptmch_trg_sched_if #(.P_NCH(5), .P_DLY_W(8), .P_WID_W(8), .P_HLD_W(16)) bus ();

  ptmch_trg_sched #(.P_NCH(5), .P_DLY_W(8), .P_WID_W(8), .P_HLD_W(16)) dut (
    .CLK160M (CLK160M),
    .RESET   (RESET),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  ch;
    int unsigned wid;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK160M);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] ch, input int unsigned wid);
    exp_t e;
    e.ch  = ch;
    e.wid = wid;
    exp_q.push_back(e);
  endtask

  task automatic pulse_in(input logic [4:0] mask);
    bus.TRG_IN = mask;
    tick();
    bus.TRG_IN = '0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    tick();
    RESET = 1'b0;
    chk("rst_trg_out", 32'(bus.TRG_OUT), 0);
    chk("rst_trg_ch",  32'(bus.TRG_CH), 0);
    chk("rst_busy",    32'(bus.BUSY), 0);
    chk("rst_pend",    32'(bus.PEND), 0);
    chk("rst_ovf",     32'(bus.OVF_STKY), 0);
    chk("rst_cnt",     32'(bus.TRG_CNT), 0);
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n;
    n = 0;
    while ((bus.BUSY || bus.PEND != '0) && n < budget) begin
      tick();
      n++;
    end
    chk("idle_in_budget", 32'(n < budget), 1);
    tick();
  endtask

  // Pulse monitor: measures each TRG_OUT pulse and matches it to the queue.
  initial begin
    logic        in_pulse;
    int unsigned w;
    logic [2:0]  ch;
    exp_t        e;
    in_pulse = 1'b0;
    w = 0;
    ch = '0;
    forever begin
      @(posedge CLK160M);
      #1;
      if (RESET) begin
        in_pulse = 1'b0;
      end else if (bus.TRG_OUT) begin
        if (!in_pulse) begin
          in_pulse = 1'b1;
          w  = 1;
          ch = bus.TRG_CH;
        end else begin
          w++;
        end
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        chk("sb_expected_pulse", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sb_ch",  32'(ch), 32'(e.ch));
          chk("sb_wid", w, e.wid);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    bus.ARM     = 1'b1;
    bus.TRG_IN  = '0;
    bus.CH_EN   = 5'b11111;
    bus.DLY_CFG = '0;
    bus.WID_CFG = 8'd4;
    bus.HLD_CFG = '0;
    bus.OVF_CLR = 1'b0;

    // 1: single ch3 event, zero delay, width 4
    do_reset();
    push_exp(3'd3, 4);
    bus.TRG_IN = 5'b01000;
    tick();
    bus.TRG_IN = '0;
    chk("t1_pend", 32'(bus.PEND), 32'h08);
    chk("t1_busy_pre", 32'(bus.BUSY), 0);
    tick();
    chk("t1_trg_out", 32'(bus.TRG_OUT), 1);
    chk("t1_trg_ch",  32'(bus.TRG_CH), 3);
    chk("t1_cnt",     32'(bus.TRG_CNT), 1);
    chk("t1_pend_clr", 32'(bus.PEND), 0);
    wait_idle(50);

    // 2: simultaneous ch0/ch2/ch4, round-robin order, holdoff 2
    do_reset();
    bus.WID_CFG = 8'd1;
    bus.HLD_CFG = 16'd2;
    push_exp(3'd0, 1);
    push_exp(3'd2, 1);
    push_exp(3'd4, 1);
    pulse_in(5'b10101);
    chk("t2_pend_all", 32'(bus.PEND), 32'h15);
    tick();
    chk("t2_pend_after_g0", 32'(bus.PEND), 32'h14);
    wait_idle(100);
    chk("t2_busy", 32'(bus.BUSY), 0);
    chk("t2_pend", 32'(bus.PEND), 0);
    chk("t2_cnt",  32'(bus.TRG_CNT), 3);

    // 3: ch1 re-triggers while already pending -> sticky overflow, one pulse
    do_reset();
    bus.WID_CFG = 8'd8;
    bus.HLD_CFG = '0;
    push_exp(3'd0, 8);
    push_exp(3'd1, 8);
    pulse_in(5'b00001);
    tick();
    pulse_in(5'b00010);
    tick();
    pulse_in(5'b00010);
    chk("t3_ovf",  32'(bus.OVF_STKY), 32'h02);
    chk("t3_pend", 32'(bus.PEND), 32'h02);
    bus.OVF_CLR = 1'b1;
    tick();
    bus.OVF_CLR = 1'b0;
    chk("t3_ovf_clr", 32'(bus.OVF_STKY), 0);
    wait_idle(100);
    chk("t3_cnt", 32'(bus.TRG_CNT), 2);

    // 4: delay 10, width 0 -> 1; DLY change mid-delay ignored
    do_reset();
    bus.DLY_CFG = 8'd10;
    bus.WID_CFG = 8'd0;
    push_exp(3'd2, 1);
    pulse_in(5'b00100);
    tick();
    chk("t4_busy", 32'(bus.BUSY), 1);
    chk("t4_no_out", 32'(bus.TRG_OUT), 0);
    n = 0;
    while (n < 40) begin
      tick();
      n++;
      if (n == 3) bus.DLY_CFG = 8'd3;
      if (bus.TRG_OUT) break;
    end
    chk("t4_delay", n, 10);
    wait_idle(50);

    // 5: masked channel / disarmed, then ARM drop during DELAY
    do_reset();
    bus.DLY_CFG = '0;
    bus.CH_EN   = 5'b11110;
    pulse_in(5'b00001);
    tick();
    chk("t5_mask_pend", 32'(bus.PEND), 0);
    chk("t5_mask_busy", 32'(bus.BUSY), 0);
    bus.CH_EN = 5'b11111;
    bus.ARM   = 1'b0;
    pulse_in(5'b00001);
    tick();
    chk("t5_disarm_pend", 32'(bus.PEND), 0);
    chk("t5_disarm_busy", 32'(bus.BUSY), 0);
    bus.ARM     = 1'b1;
    bus.DLY_CFG = 8'd5;
    push_exp(3'd1, 1);
    pulse_in(5'b00010);
    tick();
    pulse_in(5'b01000);
    chk("t5_pend3", 32'(bus.PEND), 32'h08);
    bus.ARM = 1'b0;
    tick();
    chk("t5_pend_dropped", 32'(bus.PEND), 0);
    chk("t5_still_busy", 32'(bus.BUSY), 1);
    wait_idle(50);
    chk("t5_cnt", 32'(bus.TRG_CNT), 1);
    bus.ARM = 1'b1;

    // 6: reset during PULSE aborts everything
    do_reset();
    bus.DLY_CFG = '0;
    bus.WID_CFG = 8'd20;
    pulse_in(5'b00100);
    tick();
    chk("t6_in_pulse", 32'(bus.TRG_OUT), 1);
    pulse_in(5'b10000);
    RESET = 1'b1;
    tick();
    chk("t6_trg_out", 32'(bus.TRG_OUT), 0);
    chk("t6_busy",    32'(bus.BUSY), 0);
    chk("t6_cnt",     32'(bus.TRG_CNT), 0);
    chk("t6_pend",    32'(bus.PEND), 0);
    RESET = 1'b0;
    tick();
    tick();
    chk("t6_quiet", 32'(bus.BUSY), 0);

    tick();
    chk("sb_leftover", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
